// File: rtl/scn_pkg.sv
// Shared types and defaults for the static-screen character RAM read arbiter.
package scn_pkg;

  localparam int unsigned DEF_ADDR_W        = 13;
  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_SCN_DEPTH     = 4800;
  localparam logic [7:0]  DEF_FILL_CHAR     = 8'h20;
  localparam int unsigned DEF_MAX_HOST_WAIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_HOST
  } owner_t;

endpackage

// File: rtl/scn_arb_pick.sv
// Display-priority pick with a saturating host-starvation counter that
// hands the slot to the host once it has lost MAX_HOST_WAIT arbitrations.
module scn_arb_pick
  import scn_pkg::*;
#(
  parameter int unsigned MAX_HOST_WAIT = DEF_MAX_HOST_WAIT
) (
  input  logic   i_sck,
  input  logic   i_reset,
  input  logic   i_disp_req,
  input  logic   i_host_req,
  input  logic   i_arb,
  output owner_t o_winner
);

  localparam int unsigned CNT_W = (MAX_HOST_WAIT < 1) ? 1 : $clog2(MAX_HOST_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOST_WAIT);

  logic [CNT_W-1:0] r_wait_cnt;

  always_comb begin
    o_winner = OWN_NONE;
    if (i_disp_req && i_host_req)
      o_winner = (r_wait_cnt == CNT_MAX) ? OWN_HOST : OWN_DISP;
    else if (i_disp_req)
      o_winner = OWN_DISP;
    else if (i_host_req)
      o_winner = OWN_HOST;
  end

  always_ff @(posedge i_sck) begin
    if (i_reset) begin
      r_wait_cnt <= '0;
    end else if (i_arb) begin
      if (o_winner == OWN_HOST || !i_host_req)
        r_wait_cnt <= '0;
      else if (r_wait_cnt != CNT_MAX)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scn_mem_arb.sv
// Character RAM read sequencer: arbitrates display/host reads, issues one RAM
// read per two cycles and routes the response (or fill char) to its owner.
module scn_mem_arb
  import scn_pkg::*;
#(
  parameter int unsigned       ADDR_W        = DEF_ADDR_W,
  parameter int unsigned       DATA_W        = DEF_DATA_W,
  parameter int unsigned       SCN_DEPTH     = DEF_SCN_DEPTH,
  parameter logic [DATA_W-1:0] FILL_CHAR     = DATA_W'(DEF_FILL_CHAR),
  parameter int unsigned       MAX_HOST_WAIT = DEF_MAX_HOST_WAIT
) (
  input  logic              sck,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  output logic              host_gnt,
  output logic              host_valid,
  output logic [DATA_W-1:0] host_data,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  // One extra bit so SCN_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(SCN_DEPTH);

  state_t r_state, w_state_nxt;
  owner_t r_owner, w_owner_nxt, w_winner;
  logic   r_oor, w_oor_nxt;

  logic              r_disp_gnt, w_disp_gnt_nxt, r_host_gnt, w_host_gnt_nxt;
  logic              r_disp_valid, w_disp_valid_nxt, r_host_valid, w_host_valid_nxt;
  logic [DATA_W-1:0] r_disp_data, w_disp_data_nxt, r_host_data, w_host_data_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;

  logic              w_arb, w_in_range;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_resp;

  assign w_arb      = (r_state != ST_ISSUE) && (disp_req || host_req);
  assign w_addr     = (w_winner == OWN_HOST) ? host_addr : disp_addr;
  assign w_in_range = ({1'b0, w_addr} < DEPTH_X);
  assign w_resp     = r_oor ? FILL_CHAR : mem_data;

  scn_arb_pick #(
    .MAX_HOST_WAIT(MAX_HOST_WAIT)
  ) u_pick (
    .i_sck     (sck),
    .i_reset   (reset),
    .i_disp_req(disp_req),
    .i_host_req(host_req),
    .i_arb     (w_arb),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_oor_nxt        = r_oor;
    w_disp_gnt_nxt   = 1'b0;
    w_host_gnt_nxt   = 1'b0;
    w_disp_valid_nxt = 1'b0;
    w_host_valid_nxt = 1'b0;
    w_disp_data_nxt  = r_disp_data;
    w_host_data_nxt  = r_host_data;
    w_mem_read_nxt   = 1'b0;
    w_mem_addr_nxt   = r_mem_addr;

    case (r_state)
      ST_IDLE:  ;
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
        w_oor_nxt   = 1'b0;
        if (r_owner == OWN_DISP) begin
          w_disp_data_nxt  = w_resp;
          w_disp_valid_nxt = 1'b1;
        end else if (r_owner == OWN_HOST) begin
          w_host_data_nxt  = w_resp;
          w_host_valid_nxt = 1'b1;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase

    // Arbitration in IDLE or WAIT loads the ISSUE-cycle outputs directly.
    if (w_arb) begin
      w_state_nxt    = ST_ISSUE;
      w_owner_nxt    = w_winner;
      w_oor_nxt      = !w_in_range;
      w_disp_gnt_nxt = (w_winner == OWN_DISP);
      w_host_gnt_nxt = (w_winner == OWN_HOST);
      w_mem_read_nxt = w_in_range;
      w_mem_addr_nxt = w_addr;
    end
  end

  always_ff @(posedge sck) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_oor        <= 1'b0;
      r_disp_gnt   <= 1'b0;
      r_host_gnt   <= 1'b0;
      r_disp_valid <= 1'b0;
      r_host_valid <= 1'b0;
      r_disp_data  <= '0;
      r_host_data  <= '0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_oor        <= w_oor_nxt;
      r_disp_gnt   <= w_disp_gnt_nxt;
      r_host_gnt   <= w_host_gnt_nxt;
      r_disp_valid <= w_disp_valid_nxt;
      r_host_valid <= w_host_valid_nxt;
      r_disp_data  <= w_disp_data_nxt;
      r_host_data  <= w_host_data_nxt;
      r_mem_read   <= w_mem_read_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
    end
  end

  assign disp_gnt   = r_disp_gnt;
  assign host_gnt   = r_host_gnt;
  assign disp_valid = r_disp_valid;
  assign host_valid = r_host_valid;
  assign disp_data  = r_disp_data;
  assign host_data  = r_host_data;
  assign mem_read   = r_mem_read;
  assign mem_addr   = r_mem_addr;

endmodule

// File: tb/tb_scn_mem_arb.sv
// Randomized bench for scn_mem_arb against a grant-slot reference model
// (arbitrate when no grant is showing; response lands two cycles after grant).
module tb_scn_mem_arb;

  localparam int unsigned DEPTH = 4800;
  localparam logic [7:0]  FILL  = 8'h20;
  localparam int unsigned MAXW  = 4;

  logic        sck = 1'b0;
  logic        reset = 1'b1;
  logic        disp_req = 1'b0, host_req = 1'b0;
  logic [12:0] disp_addr = '0, host_addr = '0;
  logic        disp_gnt, disp_valid, host_gnt, host_valid, mem_read;
  logic [7:0]  disp_data, host_data, mem_data = '0;
  logic [12:0] mem_addr;

  always #5 sck = ~sck;

  scn_mem_arb #(
    .ADDR_W(13), .DATA_W(8), .SCN_DEPTH(DEPTH), .FILL_CHAR(FILL), .MAX_HOST_WAIT(MAXW)
  ) dut (
    .sck(sck), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
    .host_valid(host_valid), .host_data(host_data),
    .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  // RAM model; junk on idle cycles so a fill char cannot come from the bus by luck.
  logic [7:0] ram [8192];
  always @(posedge sck) mem_data <= mem_read ? ram[mem_addr] : 8'($urandom);

  int n_chk = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: actual %0h required %0h", tag, $time, act, exp);
    end
  endtask

  // Reference model state (expected outputs for the current cycle).
  typedef struct { int due; bit host; logic [7:0] data; } resp_t;
  resp_t       q[$];
  int          cyc = 0, wait_cnt = 0;
  bit          e_dg = 0, e_hg = 0, e_rd = 0, e_dv = 0, e_hv = 0;
  logic [12:0] e_ma = '0;
  logic [7:0]  e_dd = '0, e_hd = '0;
  bit          seen_dgnt = 0, seen_hgnt = 0;
  int          starve_hgnts = 0;
  bit          in_starve = 0;

  always @(negedge sck) begin
    bit          hw;
    logic [12:0] a;
    resp_t       r;
    check_eq("disp_gnt",   disp_gnt,   e_dg);
    check_eq("host_gnt",   host_gnt,   e_hg);
    check_eq("mem_read",   mem_read,   e_rd);
    check_eq("mem_addr",   mem_addr,   e_ma);
    check_eq("disp_valid", disp_valid, e_dv);
    check_eq("host_valid", host_valid, e_hv);
    check_eq("disp_data",  disp_data,  e_dd);
    check_eq("host_data",  host_data,  e_hd);
    seen_dgnt = disp_gnt;
    seen_hgnt = host_gnt;
    if (in_starve && host_gnt) starve_hgnts++;

    if (reset) begin
      q.delete();
      wait_cnt = 0;
      {e_dg, e_hg, e_rd, e_dv, e_hv} = '0;
      e_ma = '0; e_dd = '0; e_hd = '0;
    end else begin
      bit slot_free;
      slot_free = !(e_dg || e_hg);
      e_dv = 0; e_hv = 0;
      if (q.size() > 0 && q[0].due == cyc + 1) begin
        r = q.pop_front();
        if (r.host) begin e_hv = 1; e_hd = r.data; end
        else        begin e_dv = 1; e_dd = r.data; end
      end
      e_dg = 0; e_hg = 0; e_rd = 0;
      if (slot_free && (disp_req || host_req)) begin
        hw = host_req && (!disp_req || wait_cnt == MAXW);
        if (hw || !host_req) wait_cnt = 0;
        else if (wait_cnt < MAXW) wait_cnt++;
        a    = hw ? host_addr : disp_addr;
        e_hg = hw;
        e_dg = !hw;
        e_ma = a;
        e_rd = (a < DEPTH);
        q.push_back('{due: cyc + 3, host: hw, data: (a < DEPTH) ? ram[a] : FILL});
      end
    end
    cyc++;
  end

  function automatic logic [12:0] pick_addr(input bit oor_heavy);
    logic [12:0] edges [5];
    edges = '{13'd4799, 13'd4800, 13'd7000, 13'd8191, 13'd0};
    if ($urandom_range(0, 9) < (oor_heavy ? 6 : 1))
      return edges[$urandom_range(0, 4)];
    return 13'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic two_reads(input bit ud, input logic [12:0] ad, input bit uh, input logic [12:0] ah);
    @(posedge sck); #1;
    disp_req = ud; disp_addr = ad; host_req = uh; host_addr = ah;
    for (int i = 0; i < 40 && (disp_req || host_req); i++) begin
      @(posedge sck); #1;
      if (seen_dgnt) disp_req = 0;
      if (seen_hgnt) host_req = 0;
    end
    if (disp_req || host_req) begin
      check_eq("gnt_wait_bound", 0, 1);
      disp_req = 0; host_req = 0;
    end
    repeat (4) @(posedge sck);
    #1;
  endtask

  // mode: 0 normal, 1 starvation (both always requesting), 2 out-of-range heavy, 3 with reset pulses
  task automatic run_rand(input int ncyc, input int pd, input int ph, input int mode);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge sck); #1;
      if (reset) reset = 0;
      else if (mode == 3 && $urandom_range(0, 24) == 0) reset = 1;
      if (disp_req && seen_dgnt) begin
        if (mode == 1 || $urandom_range(0, 2) != 0) disp_addr = pick_addr(mode == 2);
        else disp_req = 0;
      end else if (!disp_req && (mode == 1 || $urandom_range(0, 99) < pd)) begin
        disp_req = 1; disp_addr = pick_addr(mode == 2);
      end
      if (host_req && seen_hgnt) begin
        if (mode == 1 || $urandom_range(0, 2) != 0) host_addr = pick_addr(mode == 2);
        else host_req = 0;
      end else if (!host_req && (mode == 1 || $urandom_range(0, 99) < ph)) begin
        host_req = 1; host_addr = pick_addr(mode == 2);
      end
    end
    @(posedge sck); #1;
    reset = 0; disp_req = 0; host_req = 0;
    repeat (5) @(posedge sck);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 8'($urandom);
    ram[9] = 8'h41; ram[19] = 8'h13; ram[29] = 8'h1D; ram[4799] = 8'h5A;
    repeat (3) @(posedge sck);
    #1 reset = 0;

    two_reads(1, 13'd9, 0, '0);
    check_eq("single_disp_data", disp_data, 8'h41);
    check_eq("single_host_idle", host_data, 8'h00);
    two_reads(1, 13'd19, 1, 13'd29);
    check_eq("simul_disp_data", disp_data, 8'h13);
    check_eq("simul_host_data", host_data, 8'h1D);
    two_reads(0, '0, 1, 13'd7000);
    check_eq("oor_host_fill", host_data, FILL);
    two_reads(0, '0, 1, 13'd4799);
    check_eq("last_in_range", host_data, 8'h5A);
    two_reads(1, 13'd4800, 0, '0);
    check_eq("first_oor", disp_data, FILL);

    // Reset while a display read sits in WAIT: the response must be dropped.
    @(posedge sck); #1;
    disp_req = 1; disp_addr = 13'd39;
    for (int i = 0; i < 20 && !seen_dgnt; i++) begin @(posedge sck); #1; end
    check_eq("rst_gnt_seen", seen_dgnt, 1);
    disp_req = 0; reset = 1;
    @(posedge sck); #1 reset = 0;
    repeat (4) @(posedge sck);
    two_reads(1, 13'd59, 0, '0);
    check_eq("post_rst_data", disp_data, ram[59]);

    // Back-to-back display stream.
    begin
      logic [12:0] seq [4];
      int k;
      seq = '{13'd39, 13'd49, 13'd59, 13'd69};
      k = 0;
      @(posedge sck); #1;
      disp_req = 1; disp_addr = seq[0];
      for (int i = 0; i < 40 && k < 4; i++) begin
        @(posedge sck); #1;
        if (seen_dgnt) begin
          k++;
          if (k < 4) disp_addr = seq[k]; else disp_req = 0;
        end
      end
      check_eq("stream_grants", k, 4);
      disp_req = 0;
      repeat (5) @(posedge sck);
      #1 check_eq("stream_last_data", disp_data, ram[69]);
    end

    run_rand(300, 30, 0, 0);
    run_rand(800, 40, 40, 0);
    in_starve = 1;
    run_rand(200, 0, 0, 1);
    in_starve = 0;
    check_eq("starve_host_served", starve_hgnts > 0, 1);
    run_rand(400, 40, 40, 2);
    run_rand(600, 50, 50, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
